// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM encodings,
// widths and a magnitude helper used when latching operands.
package div_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_ITERS = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   // Unsigned magnitude of a two's-complement value; -2^31 maps to 2^31.
   function automatic logic [DIV_WIDTH-1:0] div_mag(input logic [DIV_WIDTH-1:0] v);
      return v[DIV_WIDTH-1] ? -v : v;
   endfunction

endpackage

// File: rtl/div_control.sv
// Divider sequencer: IDLE/RUN/DONE FSM plus the 5-bit iteration counter.
module divControl
   import div_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic ctrl_DIV,
   output logic load,
   output logic step,
   output logic finish,
   output logic data_resultRDY
);

   div_state_t  state;
   div_state_t  state_next;
   logic [4:0]  count;
   logic        last;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= DIV_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A start pulse wins in every state, which gives abort-and-restart in RUN
   // and back-to-back starts in DONE.
   always_comb begin
      state_next = state;
      load       = ctrl_DIV;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         DIV_IDLE: begin
            if (ctrl_DIV) state_next = DIV_RUN;
         end
         DIV_RUN: begin
            if (ctrl_DIV) begin
               state_next = DIV_RUN;
            end else if (last) begin
               finish     = 1'b1;
               state_next = DIV_DONE;
            end else begin
               step = 1'b1;
            end
         end
         DIV_DONE: begin
            state_next = ctrl_DIV ? DIV_RUN : DIV_IDLE;
         end
         default: state_next = DIV_IDLE;
      endcase
   end

   // The counter wraps after the final step, so a separate flag records that
   // all iterations are done; the following RUN cycle hands over to DONE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         last  <= 1'b0;
      end else if (load) begin
         count <= '0;
         last  <= 1'b0;
      end else if (step) begin
         count <= count + 5'd1;
         if (count == 5'(DIV_ITERS - 1)) last <= 1'b1;
      end
   end

   assign data_resultRDY = (state == DIV_DONE);

endmodule

// File: rtl/div.sv
// Sequential 32-bit signed restoring divider, one quotient bit per cycle,
// sharing the multiplier's start/ready handshake.
module div
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   logic             load;
   logic             step;
   logic             finish;

   logic [WIDTH-1:0] b_mag;
   logic             neg_q;
   logic             div_zero;
   logic             ovf;
   logic [2*WIDTH:0] rq;
   logic [2*WIDTH:0] rq_shift;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] q;

   divControl u_ctrl (
      .clock          (clock),
      .reset_n        (reset_n),
      .ctrl_DIV       (ctrl_DIV),
      .load           (load),
      .step           (step),
      .finish         (finish),
      .data_resultRDY (data_resultRDY)
   );

   assign rq_shift = rq << 1;
   assign trial    = rq_shift[2*WIDTH:WIDTH] - {1'b0, b_mag};
   assign q        = rq[WIDTH-1:0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         b_mag    <= '0;
         neg_q    <= 1'b0;
         div_zero <= 1'b0;
         ovf      <= 1'b0;
         rq       <= '0;
      end else if (load) begin
         b_mag    <= div_mag(data_operandB);
         neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         div_zero <= (data_operandB == '0);
         ovf      <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
         rq       <= {{(WIDTH+1){1'b0}}, div_mag(data_operandA)};
      end else if (step) begin
         if (!trial[WIDTH]) begin
            rq <= {trial, rq_shift[WIDTH-1:1], 1'b1};
         end else begin
            rq <= rq_shift;
         end
      end
   end

   // Overflow needs no special case: |A| / 1 = 2^31 with a positive sign
   // already yields 32'h8000_0000.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_result    <= '0;
         data_exception <= 1'b0;
      end else if (finish) begin
         data_result    <= div_zero ? '0 : (neg_q ? -q : q);
         data_exception <= div_zero | ovf;
      end
   end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for div: signs, zero divisor, overflow,
// latency, back-to-back, abort-restart and asynchronous reset.
module tb_div;

   logic        clock;
   logic        reset_n;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int total;
   int bad;

   div #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Starts an operation and waits for RDY. With chain set the caller is
   // already in the DONE cycle (1 time unit after the edge).
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic exp_e, input bit chain);
      int lat;
      if (!chain) @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      ctrl_DIV      = 1'b0;
      data_operandA = ~a;
      data_operandB = 32'd1;
      lat = 0;
      while (lat < 40 && !data_resultRDY) begin
         @(posedge clock);
         #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd33);
      check({tag, " result"}, data_result, exp_q);
      check({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_e});
   endtask

   initial begin
      int lat;
      bit seen;
      total         = 0;
      bad           = 0;
      reset_n       = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(posedge clock);
      #1;
      check("reset result", data_result, 32'd0);
      check("reset exception", {31'd0, data_exception}, 32'd0);
      check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      run_div("100/7", 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      check("100/7 rdy one cycle", {31'd0, data_resultRDY}, 32'd0);
      check("100/7 result held", data_result, 32'd14);

      run_div("-100/7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 1'b0);
      run_div("100/-7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 1'b0);
      run_div("-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0, 1'b0);
      run_div("7/100 b2b", 32'd7, 32'd100, 32'd0, 1'b0, 1'b1);
      run_div("5/0", 32'd5, 32'd0, 32'd0, 1'b1, 1'b0);
      run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
      run_div("min/2", 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 1'b0);

      // abort: 1000/10 started, restarted at cycle 15 with 81/9
      @(negedge clock);
      data_operandA = 32'd1000;
      data_operandB = 32'd10;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
      seen     = 1'b0;
      repeat (15) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) seen = 1'b1;
      end
      data_operandA = 32'd81;
      data_operandB = 32'd9;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
      if (data_resultRDY) seen = 1'b1;
      lat = 0;
      while (lat < 40 && !data_resultRDY) begin
         @(posedge clock);
         #1;
         lat++;
      end
      check("abort early rdy", {31'd0, seen}, 32'd0);
      check("abort latency", 32'(lat), 32'd33);
      check("abort result", data_result, 32'd9);

      // make outputs nonzero, then reset in the middle of a run
      run_div("min/-1 again", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
      @(negedge clock);
      data_operandA = 32'd1000;
      data_operandB = 32'd3;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      check("async reset result", data_result, 32'd0);
      check("async reset exception", {31'd0, data_exception}, 32'd0);
      check("async reset rdy", {31'd0, data_resultRDY}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      seen    = 1'b0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) seen = 1'b1;
      end
      check("no rdy after reset", {31'd0, seen}, 32'd0);
      run_div("42/6", 32'd42, 32'd6, 32'd7, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
